// File: rtl/cpu_ibus_if.sv
// Instruction-bus signal bundle between the fetch stage (master) and a memory responder (slave).
interface cpu_ibus_if;
    logic [31:0] ibus_address;
    logic        ibus_read;
    logic [31:0] ibus_data;
    logic        ibus_stall;
    logic        ibus_error;

    modport master (
        output ibus_address,
        output ibus_read,
        input  ibus_data,
        input  ibus_stall,
        input  ibus_error
    );

    modport slave (
        input  ibus_address,
        input  ibus_read,
        output ibus_data,
        output ibus_stall,
        output ibus_error
    );
endinterface

// File: rtl/cpu_ibus_responder.sv
// Instruction-bus responder: serves fetches from an on-chip preloaded memory with optional
// wait states and bus-error reporting for misaligned or out-of-window addresses.
module cpu_ibus_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'hbfc00000,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter int unsigned WAIT_WIDTH  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    cpu_ibus_if.slave             ibus,
    input  logic                  load_valid,
    input  logic [ADDR_WIDTH-1:0] load_address,
    input  logic [31:0]           load_data,
    output logic [31:0]           req_count
);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    // One past the last mapped byte, kept at 33 bits so the window never wraps.
    localparam logic [32:0] Limit = {1'b0, BASE_ADDR} + (33'(DEPTH) << 2);

    logic [31:0]           mem [DEPTH];
    state_e                state;
    logic [WAIT_WIDTH-1:0] wait_cnt;
    logic                  stall_q;
    logic                  error_q;
    logic [31:0]           data_q;
    logic                  pend_error;
    logic [31:0]           pend_data;
    logic [31:0]           count_q;

    logic                  accept;
    logic                  bad_addr;
    logic [ADDR_WIDTH-1:0] index;
    logic [31:0]           rd_word;

    always_comb begin
        accept   = ibus.ibus_read && !stall_q;
        bad_addr = (ibus.ibus_address[1:0] != 2'b00) ||
                   (ibus.ibus_address < BASE_ADDR) ||
                   ({1'b0, ibus.ibus_address} >= Limit);
        index    = ADDR_WIDTH'((ibus.ibus_address - BASE_ADDR) >> 2);
        rd_word  = bad_addr ? 32'h0 : mem[index];
    end

    // Contents survive reset; loads are accepted even while reset is held.
    always_ff @(posedge clock) begin
        if (load_valid) begin
            mem[load_address] <= load_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= StIdle;
            wait_cnt   <= '0;
            stall_q    <= 1'b0;
            error_q    <= 1'b0;
            data_q     <= 32'h0;
            pend_error <= 1'b0;
            pend_data  <= 32'h0;
            count_q    <= 32'h0;
        end else begin
            error_q <= 1'b0;
            unique case (state)
                StIdle, StResp: begin
                    if (accept) begin
                        count_q <= count_q + 32'd1;
                        if (WAIT_CYCLES == 0) begin
                            state   <= StResp;
                            error_q <= bad_addr;
                            data_q  <= rd_word;
                        end else begin
                            state      <= StWait;
                            wait_cnt   <= WAIT_WIDTH'(WAIT_CYCLES);
                            stall_q    <= 1'b1;
                            pend_error <= bad_addr;
                            pend_data  <= rd_word;
                        end
                    end else begin
                        state <= StIdle;
                    end
                end
                StWait: begin
                    wait_cnt <= wait_cnt - WAIT_WIDTH'(1);
                    if (wait_cnt == WAIT_WIDTH'(1)) begin
                        state   <= StResp;
                        stall_q <= 1'b0;
                        error_q <= pend_error;
                        data_q  <= pend_data;
                    end
                end
                default: begin
                    state   <= StIdle;
                    stall_q <= 1'b0;
                end
            endcase
        end
    end

    assign ibus.ibus_data  = data_q;
    assign ibus.ibus_stall = stall_q;
    assign ibus.ibus_error = error_q;
    assign req_count       = count_q;

endmodule
